// File: rtl/seq_det_pkg.sv
// Shared types, default sizing and saturating arithmetic for the sequence-detector match counter.
package seq_det_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_WINDOW = 16;

    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic        inc,
                                            input logic [31:0] max_val);
        if (inc && (val < max_val)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/seq_window_timer.sv
// Modulo-WINDOW cycle timer; win_end marks the last cycle of each window while running.
module seq_window_timer #(
    parameter int WINDOW = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic win_end
);

    localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);

    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;

    assign win_end = run && (tmr_q == LAST);

    always_comb begin
        tmr_d = tmr_q;
        if (clr) begin
            tmr_d = '0;
        end else if (run) begin
            tmr_d = win_end ? '0 : tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/seq_match_counter.sv
// Counts detector hits per WINDOW cycles and publishes saturated counts on a valid/ready port.
// Define SEQ_CNT_EDGE_EN to count only rising edges of z instead of every high cycle.
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WINDOW = DEF_WINDOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overrun
);

    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             run;
    logic             hit;
    logic             win_end;
    logic             consume;
    logic [CNT_W-1:0] acc_plus_hit;

    // The timer only advances on cycles that are actually counted.
    assign run = (state_q == COUNT) && en;

`ifdef SEQ_CNT_EDGE_EN
    logic z_prev_q;
    logic z_prev_d;

    // History samples in every state so a z held high across entry is not a new edge.
    assign z_prev_d = z;
    assign hit      = run && z && !z_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_prev_q <= 1'b0;
        end else begin
            z_prev_q <= z_prev_d;
        end
    end
`else
    assign hit = run && z;
`endif

    seq_window_timer #(
        .WINDOW (WINDOW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .clr     (!run),
        .win_end (win_end)
    );

    assign acc_plus_hit = CNT_W'(sat_inc(32'(acc_q), hit, CNT_MAX));
    assign consume      = valid_q && cnt_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE:    if (en)  state_d = COUNT;
            COUNT:   if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Leaving COUNT discards the partial window entirely.
        if (!run || win_end) begin
            acc_d = '0;
        end else begin
            acc_d = acc_plus_hit;
        end

        if (win_end) begin
            cnt_d   = acc_plus_hit;
            valid_d = 1'b1;
            if (valid_q && !cnt_ready) begin
                ovr_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_seq_match_counter.sv
// Directed self-checking bench for seq_match_counter (8-bit instance plus a 3-bit saturation instance).
module tb_seq_match_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       z = 1'b0;
    logic       en = 1'b0;
    logic       cnt_ready = 1'b0;
    logic [7:0] cnt_o;
    logic       cnt_valid;
    logic       overrun;
    logic [2:0] cnt3_o;
    logic       cnt3_valid;
    logic       overrun3;

    int errors = 0;
    int checks = 0;

`ifdef SEQ_CNT_EDGE_EN
    localparam int EXP_HELD  = 0;
    localparam int EXP_HELD3 = 0;
    localparam int EXP_EDGE  = 2;
`else
    localparam int EXP_HELD  = 16;
    localparam int EXP_HELD3 = 7;
    localparam int EXP_EDGE  = 15;
`endif

    always #5 clk = ~clk;

    seq_match_counter #(.CNT_W(8), .WINDOW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .z         (z),
        .en        (en),
        .cnt_o     (cnt_o),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .overrun   (overrun)
    );

    seq_match_counter #(.CNT_W(3), .WINDOW(16)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .z         (z),
        .en        (en),
        .cnt_o     (cnt3_o),
        .cnt_valid (cnt3_valid),
        .cnt_ready (cnt_ready),
        .overrun   (overrun3)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive window cycles from..to with z taken from pat[k].
    task automatic run_cycles(input logic [15:0] pat, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            z = pat[k];
            step(1);
        end
        z = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        z = 1'b0;
        en = 1'b0;
        cnt_ready = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        z = 1'b1;
        cnt_ready = 1'b0;
        step(3);
        checks++; if (cnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_o); end
        checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cnt_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst = 1'b1;
        step(1);
        step(15);
        checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL reset_early_valid: got %b expected 0", cnt_valid); end
        step(1);
        checks++; if (cnt_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b expected 1", cnt_valid); end
        checks++; if (cnt_o !== 8'(EXP_HELD)) begin errors++; $display("FAIL reset_first_cnt: got %0d expected %0d", cnt_o, EXP_HELD); end
        checks++; if (cnt3_o !== 3'(EXP_HELD3)) begin errors++; $display("FAIL reset_first_cnt3: got %0d expected %0d", cnt3_o, EXP_HELD3); end
        z = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_hits();
        do_reset();
        en = 1'b1;
        cnt_ready = 1'b1;
        step(1);
        run_cycles(16'h0224, 0, 15);
        checks++; if (cnt_valid !== 1'b1) begin errors++; $display("FAIL hits_valid: got %b expected 1", cnt_valid); end
        checks++; if (cnt_o !== 8'd3) begin errors++; $display("FAIL hits_cnt: got %0d expected 3", cnt_o); end
        step(1);
        checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL hits_valid_clear: got %b expected 0", cnt_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hits_overrun: got %b expected 0", overrun); end
        $display("test_hits done");
    endtask

    task automatic test_overrun();
        do_reset();
        en = 1'b1;
        step(1);
        run_cycles(16'h000A, 0, 15);
        checks++; if (cnt_o !== 8'd2 || cnt_valid !== 1'b1) begin errors++; $display("FAIL ovr_w1: got cnt=%0d valid=%b expected cnt=2 valid=1", cnt_o, cnt_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_w1_flag: got %b expected 0", overrun); end
        run_cycles(16'h0155, 0, 7);
        checks++; if (cnt_o !== 8'd2) begin errors++; $display("FAIL ovr_stable: got %0d expected 2", cnt_o); end
        run_cycles(16'h0155, 8, 15);
        checks++; if (cnt_o !== 8'd5) begin errors++; $display("FAIL ovr_w2_cnt: got %0d expected 5", cnt_o); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_w2_flag: got %b expected 1", overrun); end
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
        checks++; if (overrun !== 1'b1 || cnt_valid !== 1'b0) begin errors++; $display("FAIL ovr_sticky: got ovr=%b valid=%b expected ovr=1 valid=0", overrun, cnt_valid); end
        rst = 1'b0;
        #1;
        checks++; if (overrun !== 1'b0 || cnt_o !== 8'd0) begin errors++; $display("FAIL ovr_async_rst: got ovr=%b cnt=%0d expected 0 0", overrun, cnt_o); end
        rst = 1'b1;
        $display("test_overrun done");
    endtask

    task automatic test_coincident();
        do_reset();
        en = 1'b1;
        step(1);
        run_cycles(16'h0008, 0, 15);
        checks++; if (cnt_o !== 8'd1 || cnt_valid !== 1'b1) begin errors++; $display("FAIL coin_w1: got cnt=%0d valid=%b expected cnt=1 valid=1", cnt_o, cnt_valid); end
        run_cycles(16'h00AA, 0, 14);
        cnt_ready = 1'b1;
        run_cycles(16'h00AA, 15, 15);
        cnt_ready = 1'b0;
        checks++; if (cnt_o !== 8'd4 || cnt_valid !== 1'b1) begin errors++; $display("FAIL coin_w2: got cnt=%0d valid=%b expected cnt=4 valid=1", cnt_o, cnt_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coin_overrun: got %b expected 0", overrun); end
        rst = 1'b0;
        #1;
        checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL coin_async_rst_valid: got %b expected 0", cnt_valid); end
        rst = 1'b1;
        $display("test_coincident done");
    endtask

    task automatic test_saturate();
        do_reset();
        en = 1'b1;
        step(1);
        run_cycles(16'h5555, 0, 15);
        checks++; if (cnt3_o !== 3'd7 || cnt3_valid !== 1'b1) begin errors++; $display("FAIL sat_cnt3: got cnt=%0d valid=%b expected cnt=7 valid=1", cnt3_o, cnt3_valid); end
        checks++; if (cnt_o !== 8'd8) begin errors++; $display("FAIL sat_cnt8: got %0d expected 8", cnt_o); end
        $display("test_saturate done");
    endtask

    task automatic test_en_drop();
        do_reset();
        en = 1'b1;
        step(1);
        run_cycles(16'h0092, 0, 15);
        checks++; if (cnt_o !== 8'd3) begin errors++; $display("FAIL drop_w1: got %0d expected 3", cnt_o); end
        run_cycles(16'h0055, 0, 7);
        en = 1'b0;
        step(3);
        checks++; if (cnt_o !== 8'd3 || cnt_valid !== 1'b1) begin errors++; $display("FAIL drop_pending: got cnt=%0d valid=%b expected cnt=3 valid=1", cnt_o, cnt_valid); end
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
        checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL drop_consume: got %b expected 0", cnt_valid); end
        en = 1'b1;
        step(1);
        run_cycles(16'h0408, 0, 14);
        checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL drop_early_end: got %b expected 0", cnt_valid); end
        run_cycles(16'h0408, 15, 15);
        checks++; if (cnt_o !== 8'd2 || cnt_valid !== 1'b1) begin errors++; $display("FAIL drop_new_cnt: got cnt=%0d valid=%b expected cnt=2 valid=1", cnt_o, cnt_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL drop_overrun: got %b expected 0", overrun); end
        $display("test_en_drop done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        cnt_ready = 1'b1;
        step(1);
        for (int w = 0; w < 3; w++) begin
            run_cycles(16'h5555, 0, 14);
            checks++; if (cnt_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap w=%0d: got %b expected 0", w, cnt_valid); end
            run_cycles(16'h5555, 15, 15);
            checks++; if (cnt_valid !== 1'b1 || cnt_o !== 8'd8) begin errors++; $display("FAIL b2b_report w=%0d: got cnt=%0d valid=%b expected cnt=8 valid=1", w, cnt_o, cnt_valid); end
        end
        cnt_ready = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_edge();
        do_reset();
        en = 1'b1;
        step(1);
        run_cycles(16'hFFDF, 0, 15);
        checks++; if (cnt_o !== 8'(EXP_EDGE) || cnt_valid !== 1'b1) begin errors++; $display("FAIL edge_cnt: got cnt=%0d valid=%b expected cnt=%0d valid=1", cnt_o, cnt_valid, EXP_EDGE); end
        $display("test_edge done");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hits();
        test_overrun();
        test_coincident();
        test_saturate();
        test_en_drop();
        test_back_to_back();
        test_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_match_counter.md
# seq_match_counter

Downstream stage of the gate-level sequence detector: consumes the detector's `z` output and counts detections over fixed windows of `WINDOW` clock cycles. At each window end it publishes the saturated count on a valid/ready report port and flags reports that were lost because the consumer did not take them in time. It turns the raw detect pulse into a rate metric for the monitor/CSR side of the design.

## Interface
- `CNT_W`, 8, width of the match count and the report port
- `WINDOW`, 16, window length in clock cycles (≥2)
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  reset, asynchronous, active-low (asserted when 0)
- `z`  input  1  detect output of the sequence detector, sampled every clock
- `en`  input  1  counting enable; 0 holds the block idle
- `cnt_o`  output  CNT_W  count of the last completed window
- `cnt_valid`  output  1  `cnt_o` holds an unconsumed report
- `cnt_ready`  input  1  consumer accepts the report when high with `cnt_valid`
- `overrun`  output  1  sticky: a report was overwritten before acceptance

## Operation
- States: IDLE, COUNT. IDLE→COUNT at a rising edge with `en`=1; COUNT→IDLE at a rising edge with `en`=0.
- In COUNT: window timer runs 0..WINDOW-1, wraps to 0; accumulator adds 1 for each counted cycle (default: `z`=1 that cycle).
- Accumulator saturates at 2^CNT_W−1; it never wraps.
- Window end (timer = WINDOW-1): report ← accumulator plus that cycle's hit (saturated); accumulator ← 0; `cnt_valid` ← 1.
- Handshake: a report is consumed on a rising edge with `cnt_valid` & `cnt_ready`; `cnt_valid` then clears unless a new window ends on the same edge.
- Window end while `cnt_valid`=1 and not consumed that edge: `cnt_o` overwritten, `overrun` ← 1. Window end coincident with consumption: new report loaded, `cnt_valid` stays 1, no overrun.
- `cnt_o` is stable while `cnt_valid`=1 and no window end occurs.
- `en` dropped mid-window: partial count and timer discarded (both 0); a pending report stays valid until consumed.
- `overrun` clears only on reset.

## Timing
- Reset values: `cnt_o`=0, `cnt_valid`=0, `overrun`=0, state IDLE, timer 0, accumulator 0, edge history 0.
- First counted cycle is the cycle after the edge that enters COUNT.
- Latency: `z` in the last window cycle is included; `cnt_valid`/`cnt_o` update on the next rising edge.
- Report period is exactly WINDOW cycles while `en` stays high.
- Reset asserted mid-window or mid-handshake: all state returns to reset values immediately; pending report lost, no overrun raised.

## Configuration
- `SEQ_CNT_EDGE_EN` defined: a cycle counts only on a rising edge of `z` (`z`=1 and previous-cycle `z`=0); the previous-`z` register samples every cycle in all states, so a `z` held high across IDLE→COUNT does not count.
- Not defined: every cycle with `z`=1 in COUNT counts; no history register.

## Structure
- Package `seq_det_pkg`: state enum (IDLE, COUNT), default `CNT_W`/`WINDOW` constants, saturating-increment function.
- One sub-module: `seq_window_timer` (modulo-WINDOW counter with clear, emits `win_end`).
- Top holds FSM, accumulator, report register, handshake and overrun logic.

## Test plan
- Reset with `z`=1, `en`=1 held: all outputs 0 while `rst`=0; after release, first report after 16 cycles equals 16.
- `en`=1, `z` pulsed high 3 cycles (non-adjacent) in a window, `cnt_ready`=1 → `cnt_o`=3, `cnt_valid` high one cycle.
- `cnt_ready`=0 for two windows with 2 then 5 hits → `cnt_o`=5, `overrun`=1; `cnt_ready`=1 at the exact window-end edge → no overrun.
- `CNT_W`=3, `z`=1 whole window → `cnt_o`=7 (saturated, not 0).
- `en` dropped at cycle 8 of a window after 4 hits, re-raised → next report counts only new-window hits; pending report unchanged.
- `SEQ_CNT_EDGE_EN` defined, `z` high for 5 consecutive cycles, then 0, then 1 → `cnt_o`=2.
